lcd_dbi_receiver: RTL and testbench

LCD_DBI_RECEIVER -- requirements
Module: lcd_dbi_receiver

---
 rtl/lcd_dbi_pkg.sv | 26 ++
 rtl/lcd_dbi_if.sv | 25 ++
 rtl/lcd_dbi_sync.sv | 75 +++++++
 rtl/lcd_dbi_receiver.sv | 105 ++++++++++
 tb/tb_lcd_dbi_receiver.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_dbi_pkg.sv
// Shared constants, state encoding and bus payload type for the 8080-style LCD DBI receiver.
package lcd_dbi_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned PIX_W  = 2 * DATA_W;

   localparam logic [DATA_W-1:0] CMD_RAMWR  = 8'h2C;
   localparam logic [DATA_W-1:0] CMD_RAMWRC = 8'h3C;

   typedef enum logic [1:0] {
      S_PARAM  = 2'd0,
      S_PIX_HI = 2'd1,
      S_PIX_LO = 2'd2
   } state_e;

   // One captured bus write: data/command select plus the byte.
   typedef struct packed {
      logic              dcx;
      logic [DATA_W-1:0] data;
   } bus_word_t;

   function automatic logic is_pixel_cmd(input logic [DATA_W-1:0] b);
      return (b == CMD_RAMWR) || (b == CMD_RAMWRC);
   endfunction

endpackage

// File: rtl/lcd_dbi_if.sv
// LCD DBI pin bundle plus the decoded receiver outputs.
interface lcd_dbi_if;
   import lcd_dbi_pkg::*;

   logic              i_lcd_csx;
   logic              i_lcd_dcx;
   logic              i_lcd_wrx;
   logic [DATA_W-1:0] i_lcd_data;
   logic [DATA_W-1:0] o_command;
   logic              o_command_latch;
   logic [DATA_W-1:0] o_param;
   logic              o_param_latch;
   logic [PIX_W-1:0]  o_rgb565;
   logic              o_rgb565_latch;

   modport master (
      output i_lcd_csx, i_lcd_dcx, i_lcd_wrx, i_lcd_data,
      input  o_command, o_command_latch, o_param, o_param_latch, o_rgb565, o_rgb565_latch
   );

   modport slave (
      input  i_lcd_csx, i_lcd_dcx, i_lcd_wrx, i_lcd_data,
      output o_command, o_command_latch, o_param, o_param_latch, o_rgb565, o_rgb565_latch
   );
endinterface

// File: rtl/lcd_dbi_sync.sv
// Synchronizes the LCD pins into i_clk and emits registered write strobe, captured word and CSX-rise.
module lcd_dbi_sync
   import lcd_dbi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lcd_csx,
   input  logic              i_lcd_dcx,
   input  logic              i_lcd_wrx,
   input  logic [DATA_W-1:0] i_lcd_data,
   output logic              o_wr_stb,
   output bus_word_t         o_word,
   output logic              o_csx_rise
);

   localparam int unsigned LAST = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0]             csx_q, csx_d;
   logic [SYNC_STAGES-1:0]             wrx_q, wrx_d;
   logic [SYNC_STAGES-1:0]             dcx_q, dcx_d;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] data_q, data_d;
   logic                               wrx_last_q, wrx_last_d;
   logic                               csx_last_q, csx_last_d;
   logic                               wr_stb_q, wr_stb_d;
   bus_word_t                          word_q, word_d;
   logic                               csx_rise_q, csx_rise_d;

   always_comb begin
      csx_d      = {csx_q[SYNC_STAGES-2:0], i_lcd_csx};
      wrx_d      = {wrx_q[SYNC_STAGES-2:0], i_lcd_wrx};
      dcx_d      = {dcx_q[SYNC_STAGES-2:0], i_lcd_dcx};
      data_d     = {data_q[SYNC_STAGES-2:0], i_lcd_data};
      wrx_last_d = wrx_q[LAST];
      csx_last_d = csx_q[LAST];
      // DCX and data come from the same stage as the WRX sample that forms the edge.
      wr_stb_d   = wrx_q[LAST] & ~wrx_last_q & ~csx_q[LAST];
      word_d     = word_q;
      if (wr_stb_d) begin
         word_d = '{dcx: dcx_q[LAST], data: data_q[LAST]};
      end
      csx_rise_d = csx_q[LAST] & ~csx_last_q;
   end

   // Reset preloads the chain to an idle bus so release never fakes an edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         csx_q      <= '1;
         wrx_q      <= '1;
         dcx_q      <= '0;
         data_q     <= '0;
         wrx_last_q <= 1'b1;
         csx_last_q <= 1'b1;
         wr_stb_q   <= 1'b0;
         word_q     <= '0;
         csx_rise_q <= 1'b0;
      end else begin
         csx_q      <= csx_d;
         wrx_q      <= wrx_d;
         dcx_q      <= dcx_d;
         data_q     <= data_d;
         wrx_last_q <= wrx_last_d;
         csx_last_q <= csx_last_d;
         wr_stb_q   <= wr_stb_d;
         word_q     <= word_d;
         csx_rise_q <= csx_rise_d;
      end
   end

   assign o_wr_stb   = wr_stb_q;
   assign o_word     = word_q;
   assign o_csx_rise = csx_rise_q;

endmodule

// File: rtl/lcd_dbi_receiver.sv
// Decodes synchronized DBI writes into command, parameter and RGB565 pixel outputs.
module lcd_dbi_receiver
   import lcd_dbi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   lcd_dbi_if.slave bus
);

   logic      wr_stb;
   bus_word_t word;
   logic      csx_rise;

   lcd_dbi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_lcd_csx  (bus.i_lcd_csx),
      .i_lcd_dcx  (bus.i_lcd_dcx),
      .i_lcd_wrx  (bus.i_lcd_wrx),
      .i_lcd_data (bus.i_lcd_data),
      .o_wr_stb   (wr_stb),
      .o_word     (word),
      .o_csx_rise (csx_rise)
   );

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] command_q, command_d;
   logic [DATA_W-1:0] param_q, param_d;
   logic [PIX_W-1:0]  rgb_q, rgb_d;
   logic              cmd_latch_q, cmd_latch_d;
   logic              par_latch_q, par_latch_d;
   logic              rgb_latch_q, rgb_latch_d;

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      command_d   = command_q;
      param_d     = param_q;
      rgb_d       = rgb_q;
      cmd_latch_d = 1'b0;
      par_latch_d = 1'b0;
      rgb_latch_d = 1'b0;
      if (wr_stb) begin
         if (!word.dcx) begin
            command_d   = word.data;
            cmd_latch_d = 1'b1;
            state_d     = is_pixel_cmd(word.data) ? S_PIX_HI : S_PARAM;
         end else begin
            unique case (state_q)
               S_PARAM: begin
                  param_d     = word.data;
                  par_latch_d = 1'b1;
               end
               S_PIX_HI: begin
                  hi_d    = word.data;
                  state_d = S_PIX_LO;
               end
               S_PIX_LO: begin
                  rgb_d       = {hi_q, word.data};
                  rgb_latch_d = 1'b1;
                  state_d     = S_PIX_HI;
               end
               default: state_d = S_PARAM;
            endcase
         end
      end else if (csx_rise && (state_q == S_PIX_LO)) begin
         // Deselect drops a half pixel but stays in pixel mode for a RAMWRC resume.
         hi_d    = '0;
         state_d = S_PIX_HI;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_PARAM;
         hi_q        <= '0;
         command_q   <= '0;
         param_q     <= '0;
         rgb_q       <= '0;
         cmd_latch_q <= 1'b0;
         par_latch_q <= 1'b0;
         rgb_latch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         command_q   <= command_d;
         param_q     <= param_d;
         rgb_q       <= rgb_d;
         cmd_latch_q <= cmd_latch_d;
         par_latch_q <= par_latch_d;
         rgb_latch_q <= rgb_latch_d;
      end
   end

   assign bus.o_command       = command_q;
   assign bus.o_command_latch = cmd_latch_q;
   assign bus.o_param         = param_q;
   assign bus.o_param_latch   = par_latch_q;
   assign bus.o_rgb565        = rgb_q;
   assign bus.o_rgb565_latch  = rgb_latch_q;

endmodule

// File: tb/tb_lcd_dbi_receiver.sv
// Scoreboard bench for lcd_dbi_receiver: directed scenarios then random DBI traffic vs a transaction-level model.
module tb_lcd_dbi_receiver;

   localparam int unsigned SS = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   lcd_dbi_if bus ();

   lcd_dbi_receiver #(.SYNC_STAGES(SS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      int          kind;   // 0 command, 1 param, 2 pixel
      logic [15:0] val;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Transaction-level model of the receiver
   bit       m_pix_mode = 1'b0;
   bit       m_have_hi  = 1'b0;
   bit [7:0] m_hi       = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_exp(input int kind, input logic [15:0] val, input int at);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = at + int'(SS) + 2;
      sb.push_back(e);
   endfunction

   function automatic void model_write(input bit dcx, input bit [7:0] b, input int at);
      if (!dcx) begin
         push_exp(0, {8'h00, b}, at);
         m_pix_mode = (b == 8'h2C) || (b == 8'h3C);
         m_have_hi  = 1'b0;
      end else if (!m_pix_mode) begin
         push_exp(1, {8'h00, b}, at);
      end else if (!m_have_hi) begin
         m_hi      = b;
         m_have_hi = 1'b1;
      end else begin
         push_exp(2, {m_hi, b}, at);
         m_have_hi = 1'b0;
      end
   endfunction

   // Monitor: pops the scoreboard on every latch pulse and checks held values otherwise.
   logic [7:0]  h_cmd = 8'h00;
   logic [7:0]  h_par = 8'h00;
   logic [15:0] h_rgb = 16'h0000;

   always @(negedge clk) begin
      int   nl;
      int   kind;
      exp_t e;
      if (!rst_n) begin
         h_cmd = 8'h00;
         h_par = 8'h00;
         h_rgb = 16'h0000;
      end else begin
         nl = int'(bus.o_command_latch) + int'(bus.o_param_latch) + int'(bus.o_rgb565_latch);
         if (nl != 0) begin
            check("one_latch", nl, 1);
            kind = bus.o_command_latch ? 0 : (bus.o_param_latch ? 1 : 2);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: kind %0d with empty scoreboard (cycle %0d)", kind, cyc);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", kind, e.kind);
               check("latency", cyc, e.cyc);
               case (e.kind)
                  0:       h_cmd = e.val[7:0];
                  1:       h_par = e.val[7:0];
                  default: h_rgb = e.val;
               endcase
            end
         end
         check("o_command", bus.o_command, h_cmd);
         check("o_param",   bus.o_param,   h_par);
         check("o_rgb565",  bus.o_rgb565,  h_rgb);
      end
   end

   task automatic wr(input bit dcx, input bit [7:0] b);
      @(negedge clk);
      bus.i_lcd_dcx  = dcx;
      bus.i_lcd_data = b;
      bus.i_lcd_wrx  = 1'b0;
      repeat ($urandom_range(2, 3)) @(negedge clk);
      bus.i_lcd_wrx = 1'b1;
      if (bus.i_lcd_csx == 1'b0) model_write(dcx, b, cyc);
      repeat ($urandom_range(2, 3)) @(negedge clk);
   endtask

   task automatic deselect(input int toggles);
      repeat (2) @(negedge clk);
      bus.i_lcd_csx = 1'b1;
      m_have_hi = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < toggles; i++) wr(1'($urandom_range(0, 1)), 8'($urandom));
      repeat (2) @(negedge clk);
      bus.i_lcd_csx = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      drain();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_command",   bus.o_command, 0);
      check("rst_param",     bus.o_param, 0);
      check("rst_rgb",       bus.o_rgb565, 0);
      check("rst_latches",   {bus.o_command_latch, bus.o_param_latch, bus.o_rgb565_latch}, 0);
      m_pix_mode = 1'b0;
      m_have_hi  = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      bus.i_lcd_csx  = 1'b1;
      bus.i_lcd_dcx  = 1'b0;
      bus.i_lcd_wrx  = 1'b1;
      bus.i_lcd_data = 8'h00;
      do_reset();
      bus.i_lcd_csx = 1'b0;
      repeat (3) @(negedge clk);

      // Command with four parameters
      wr(1'b0, 8'h2A);
      wr(1'b1, 8'h00); wr(1'b1, 8'h00); wr(1'b1, 8'h00); wr(1'b1, 8'hEF);
      drain();
      // Pixel stream
      wr(1'b0, 8'h2C);
      wr(1'b1, 8'hF8); wr(1'b1, 8'h00); wr(1'b1, 8'h07); wr(1'b1, 8'hE0);
      drain();
      // Deselect drops a half pixel
      wr(1'b0, 8'h2C);
      wr(1'b1, 8'h12);
      deselect(0);
      wr(1'b1, 8'h34); wr(1'b1, 8'h56);
      drain();
      // WRX toggles with CSX high are ignored, in param and pixel mode
      wr(1'b0, 8'h2A);
      deselect(5);
      wr(1'b1, 8'h55);
      wr(1'b0, 8'h2C);
      deselect(5);
      wr(1'b1, 8'h9A); wr(1'b1, 8'hBC);
      drain();
      // Reset mid-pixel
      wr(1'b0, 8'h2C);
      wr(1'b1, 8'h77);
      do_reset();
      wr(1'b1, 8'h11);
      drain();
      // RAMWR then RAMWRC resume
      wr(1'b0, 8'h2C);
      wr(1'b1, 8'hAB); wr(1'b1, 8'hCD);
      wr(1'b0, 8'h3C);
      wr(1'b1, 8'h01); wr(1'b1, 8'h02);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 12)      wr(1'b0, ($urandom_range(0, 1) != 0) ? 8'h2C : 8'h3C);
         else if (r < 20) wr(1'b0, 8'($urandom));
         else if (r < 88) wr(1'b1, 8'($urandom));
         else if (r < 97) deselect(int'($urandom_range(0, 3)));
         else             do_reset();
      end
      drain();
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
